shift_seq_ctrl: RTL and testbench

Sequencer that owns the cmd/par_in/ser_in inputs of one shift_register instance. It accepts a job (operation, seed word, step count, fill bit) over a valid/ready request port. It drives one Load cycle, then exactly N shift/rotate cycles, then presents the result on a valid/ready response port. The datapath register has no hold command, so the controller implements hold by reloading the register's own output.

---
 rtl/shift_seq_ctrl_if.sv | 38 +++
 rtl/shift_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl_if
// Request/response bundle between a job producer and shift_seq_ctrl.
//   req_valid/req_ready : job handshake (producer -> controller)
//   req_op              : 0 rotate-left, 1 rotate-right, 2 shift-right+fill,
//                         3 load only
//   req_data            : seed word
//   req_count           : number of shift/rotate steps
//   req_fill            : serial bit inserted at the MSB on shift-right
//   rsp_valid/rsp_ready : result handshake (controller -> consumer)
//   rsp_data            : result word
// The master modport is the job producer / result consumer side; the slave
// modport is the controller side.
// ---------------------------------------------------------------------------
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) ();
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_data;
    logic [CNT_W-1:0] req_count;
    logic             req_fill;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_op, req_data, req_count, req_fill, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_data, req_count, req_fill, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl
// Sequencer owning the cmd/par_in/ser_in inputs of one shift register.
// A job (op, seed, step count, fill bit) is accepted over the request port,
// the register is loaded once, shifted/rotated exactly `count` times and the
// result is presented on the response port until consumed.
//
// The shift register has no hold command, so whenever the controller wants
// the register to keep its value it issues Load with par_in = data_out.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   bus          request/response bundle (slave side)
//   busy         high in any state other than IDLE
//   sr_cmd       to register: 0 Load, 1 RotateLeft, 2 RotateRight,
//                3 ShiftRight
//   sr_par_in    to register parallel input
//   sr_ser_in    to register serial input (MSB side on shift-right)
//   sr_data_out  from register parallel output
// ---------------------------------------------------------------------------
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    shift_seq_ctrl_if.slave       bus,
    output logic                  busy,
    output logic [1:0]            sr_cmd,
    output logic [WIDTH-1:0]      sr_par_in,
    output logic                  sr_ser_in,
    input  logic [WIDTH-1:0]      sr_data_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] CMD_LOAD  = 2'd0;
    localparam logic [1:0] OP_SRFILL = 2'd2;
    localparam logic [1:0] OP_LOADONLY = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fill_q, fill_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    // -----------------------------------------------------------------------
    // State and job registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            data_q  <= '0;
            count_q <= '0;
            fill_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            count_q <= count_d;
            fill_q  <= fill_d;
            rem_q   <= rem_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and register-side outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        count_d   = count_q;
        fill_d    = fill_q;
        rem_d     = rem_q;
        // Default is the hold rule: reload the register with its own value.
        sr_cmd    = CMD_LOAD;
        sr_par_in = sr_data_out;
        sr_ser_in = 1'b0;

        case (state_q)
            S_IDLE: begin
                // req_ready is high here; a reset in the same cycle is
                // overridden by the register process.
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    data_d  = bus.req_data;
                    count_d = bus.req_count;
                    fill_d  = bus.req_fill;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                sr_par_in = data_q;
                if ((count_q == CNT_ZERO) || (op_q == OP_LOADONLY)) begin
                    state_d = S_RESP;
                end else begin
                    rem_d   = count_q;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                // op 0/1/2 map directly onto register commands 1/2/3.
                sr_cmd    = op_q + 2'd1;
                sr_ser_in = (op_q == OP_SRFILL) ? fill_q : 1'b0;
                rem_d     = rem_q - CNT_ONE;
                if (rem_q == CNT_ONE) begin
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // While reset is asserted the register must not move, whatever
        // state we were in.
        if (rst) begin
            sr_cmd    = CMD_LOAD;
            sr_par_in = sr_data_out;
            sr_ser_in = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Handshake outputs
    // -----------------------------------------------------------------------
    assign bus.req_ready = (state_q == S_IDLE) && !rst;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_data  = sr_data_out;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

    localparam int W     = 8;
    localparam int CW    = 4;
    localparam int MASK  = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          busy;
    logic [1:0]    sr_cmd;
    logic [W-1:0]  sr_par_in;
    logic          sr_ser_in;
    logic [W-1:0]  sr_q = '0;

    int checks = 0;
    int errors = 0;

    logic [1:0]   cmd_log[$];
    logic [W-1:0] val_log[$];

    shift_seq_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    shift_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .sr_cmd      (sr_cmd),
        .sr_par_in   (sr_par_in),
        .sr_ser_in   (sr_ser_in),
        .sr_data_out (sr_q)
    );

    always #5 clk = ~clk;

    // Behavioural shift register controlled by the DUT.
    always @(posedge clk) begin
        case (sr_cmd)
            2'd0: sr_q <= sr_par_in;
            2'd1: sr_q <= {sr_q[W-2:0], sr_q[W-1]};
            2'd2: sr_q <= {sr_q[0], sr_q[W-1:1]};
            default: sr_q <= {sr_ser_in, sr_q[W-1:1]};
        endcase
    end

    // Expected result of a job, from plain arithmetic on the job parameters.
    function automatic logic [W-1:0] model(input int op, input int d, input int n, input int f);
        int k;
        int r;
        k = n % W;
        case (op)
            0: r = ((d << k) | (d >> (W - k))) & MASK;
            1: r = ((d >> k) | (d << (W - k))) & MASK;
            2: begin
                if (n >= W) r = f ? MASK : 0;
                else        r = (d >> n) | (f ? (MASK & ~(MASK >> n)) : 0);
            end
            default: r = d;
        endcase
        return W'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one job, follow it to the response, optionally stall the
    // response for `hold` cycles, then consume it.
    task automatic run_job(input logic [1:0] op, input logic [W-1:0] data,
                           input logic [CW-1:0] count, input logic fill,
                           input logic [W-1:0] exp, input int hold, input string name);
        int w;
        int cycles;
        int shifts;
        bit load_only;
        load_only = (op == 2'd3) || (count == 0);
        cmd_log.delete();
        val_log.delete();

        w = 0;
        while (!bus.req_ready && w < 50) begin
            tick();
            w++;
        end
        chk({name, "_ready"}, bus.req_ready, 1);

        bus.rsp_ready = (hold == 0);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_data  = data;
        bus.req_count = count;
        bus.req_fill  = fill;
        tick();
        // Accepted; from here req_* must be ignored.
        bus.req_valid = 1'b0;
        bus.req_op    = 2'($urandom);
        bus.req_data  = W'($urandom);
        bus.req_count = CW'($urandom);
        bus.req_fill  = 1'($urandom);

        chk({name, "_load_par"}, sr_par_in, data);
        chk({name, "_busy"}, busy, 1);

        cycles = 0;
        shifts = 0;
        while (!bus.rsp_valid && cycles < 100) begin
            cmd_log.push_back(sr_cmd);
            val_log.push_back(sr_q);
            if (sr_cmd != 2'd0) shifts++;
            tick();
            cycles++;
        end
        chk({name, "_latency"}, cycles, load_only ? 1 : 1 + count);
        chk({name, "_shifts"}, shifts, load_only ? 0 : count);
        chk({name, "_rsp_data"}, bus.rsp_data, exp);

        for (int h = 0; h < hold; h++) begin
            chk({name, "_bp_valid"}, bus.rsp_valid, 1);
            chk({name, "_bp_data"}, bus.rsp_data, exp);
            chk({name, "_bp_cmd"}, sr_cmd, 0);
            chk({name, "_bp_req_ready"}, bus.req_ready, 0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk({name, "_rsp_drop"}, bus.rsp_valid, 0);
        chk({name, "_idle"}, busy, 0);
        chk({name, "_reg_kept"}, sr_q, exp);
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [W-1:0]  data;
        logic [CW-1:0] count;
        logic          fill;
        logic [W-1:0]  exp;
        int            hold;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{2'd0, 8'h81, 4'd1,  1'b0, 8'h03, 0};
        vecs[1] = '{2'd1, 8'h01, 4'd3,  1'b0, 8'h20, 0};
        vecs[2] = '{2'd2, 8'hF0, 4'd4,  1'b1, 8'hFF, 0};
        vecs[3] = '{2'd2, 8'hF0, 4'd4,  1'b0, 8'h0F, 0};
        vecs[4] = '{2'd0, 8'hA5, 4'd0,  1'b0, 8'hA5, 0};
        vecs[5] = '{2'd3, 8'h3C, 4'd5,  1'b0, 8'h3C, 0};
        vecs[6] = '{2'd0, 8'h81, 4'd8,  1'b0, 8'h81, 5};
        vecs[7] = '{2'd0, 8'h5A, 4'd15, 1'b0, 8'h2D, 0};
        vecs[8] = '{2'd2, 8'h80, 4'd15, 1'b0, 8'h00, 1};

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_data  = '0;
        bus.req_count = '0;
        bus.req_fill  = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_cmd", sr_cmd, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", bus.req_ready, 1);

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            run_job(vecs[i].op, vecs[i].data, vecs[i].count, vecs[i].fill,
                    vecs[i].exp, vecs[i].hold, $sformatf("vec%0d", i));
            if (i == 1) begin
                chk("rr_cmd_len", cmd_log.size(), 4);
                for (int j = 0; j < cmd_log.size() && j < 4; j++)
                    chk($sformatf("rr_cmd%0d", j), cmd_log[j], (j == 0) ? 0 : 2);
            end
            if (i == 2) begin
                chk("sr_step1", val_log[2], 8'hF8);
                chk("sr_step2", val_log[3], 8'hFC);
                chk("sr_step3", val_log[4], 8'hFE);
            end
        end

        // Reset during the second RUN cycle of RR count=6 on 0x80.
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd1;
        bus.req_data  = 8'h80;
        bus.req_count = 4'd6;
        bus.req_fill  = 1'b0;
        tick();                 // accepted
        bus.req_valid = 1'b0;
        tick();                 // Load edge
        chk("mid_run1_cmd", sr_cmd, 2);
        tick();                 // first shift edge
        chk("mid_run2_cmd", sr_cmd, 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_cmd", sr_cmd, 0);
        chk("mid_rst_par", sr_par_in, sr_q);
        chk("mid_rst_req_ready", bus.req_ready, 0);
        tick();
        rst = 1'b0;
        chk("mid_busy", busy, 0);
        chk("mid_frozen", sr_q, 8'h40);
        for (int k = 0; k < 4; k++) begin
            chk("mid_no_rsp", bus.rsp_valid, 0);
            tick();
        end
        chk("mid_frozen2", sr_q, 8'h40);
        run_job(2'd1, 8'h80, 4'd6, 1'b0, 8'h02, 0, "after_rst");

        // Randomized jobs against the arithmetic model
        for (int r = 0; r < 40; r++) begin
            logic [1:0]    op;
            logic [W-1:0]  d;
            logic [CW-1:0] n;
            logic          f;
            op = 2'($urandom_range(0, 3));
            d  = W'($urandom);
            n  = CW'($urandom);
            f  = 1'($urandom);
            run_job(op, d, n, f, model(op, d, n, f), $urandom_range(0, 3),
                    $sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
